// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single register-file write port between the
// pipeline writeback stage (A, priority) and a multicycle unit (B, FIFO-buffered).
// A starvation counter forces one B grant by stalling the pipeline for a cycle.
//
// Ports:
//   clock_i, rst_i                    clock (rising edge), async active-high reset
//   wb_valid_i/wb_rd_i/wb_data_i      pipeline writeback request
//   mc_valid_i/mc_rd_i/mc_data_i      multicycle result, accepted when mc_ready_o
//   mc_ready_o                        FIFO not full (low while in reset)
//   rf_we_o/rf_rd_o/rf_data_o         registered register-file write port
//   stall_o                           one-cycle pipeline hold on B starvation
//   busy_mask_o                       registers with a B result still pending
module wb_port_arbiter #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                     clock_i,
    input  logic                     rst_i,
    input  logic                     wb_valid_i,
    input  logic [ADDR_W-1:0]        wb_rd_i,
    input  logic [DATA_W-1:0]        wb_data_i,
    input  logic                     mc_valid_i,
    output logic                     mc_ready_o,
    input  logic [ADDR_W-1:0]        mc_rd_i,
    input  logic [DATA_W-1:0]        mc_data_i,
    output logic                     rf_we_o,
    output logic [ADDR_W-1:0]        rf_rd_o,
    output logic [DATA_W-1:0]        rf_data_o,
    output logic                     stall_o,
    output logic [(2**ADDR_W)-1:0]   busy_mask_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [ADDR_W-1:0] fifo_rd_q   [DEPTH];
    logic [DATA_W-1:0] fifo_data_q [DEPTH];
    logic [OCC_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]  count;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stall_q;
    logic              rf_we_q, rf_from_b_q;
    logic [ADDR_W-1:0] rf_rd_q;
    logic [DATA_W-1:0] rf_data_q;
    logic              empty, full, accept, grant_a, grant_b;
    logic [PTR_W-1:0]  head_idx;
    logic [PTR_W-1:0]  idx;

    // Occupancy from the extra pointer bit distinguishes full from empty
    assign count      = wr_ptr_q - rd_ptr_q;
    assign empty      = (count == '0);
    assign full       = (count == OCC_W'(DEPTH));
    assign mc_ready_o = !full && !rst_i;
    assign accept     = mc_valid_i && mc_ready_o;
    assign head_idx   = rd_ptr_q[PTR_W-1:0];

    // While stalled the pipeline re-presents its request, so B wins outright
    assign grant_b = !empty && (stall_q || !wb_valid_i);
    assign grant_a = wb_valid_i && !(stall_q && !empty);

    // Starvation counter: cleared when nothing waits or the head is served
    always_comb begin
        cnt_d = cnt_q;
        if (empty || grant_b) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(STARVE_LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Pending-register mask: live FIFO entries plus a B write in the output stage
    always_comb begin
        busy_mask_o = '0;
        idx         = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            idx = head_idx + PTR_W'(i);
            if (OCC_W'(i) < count) begin
                busy_mask_o[fifo_rd_q[idx]] = 1'b1;
            end
        end
        if (rf_we_q && rf_from_b_q) begin
            busy_mask_o[rf_rd_q] = 1'b1;
        end
    end

    // FIFO payload storage; validity is tracked by the pointers alone
    always_ff @(posedge clock_i) begin
        if (accept) begin
            fifo_rd_q[wr_ptr_q[PTR_W-1:0]]   <= mc_rd_i;
            fifo_data_q[wr_ptr_q[PTR_W-1:0]] <= mc_data_i;
        end
    end

    // Pointers, starvation state and registered write port
    always_ff @(posedge clock_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            stall_q     <= 1'b0;
            rf_we_q     <= 1'b0;
            rf_from_b_q <= 1'b0;
            rf_rd_q     <= '0;
            rf_data_q   <= '0;
        end else begin
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + OCC_W'(1);
            end
            if (grant_b) begin
                rd_ptr_q <= rd_ptr_q + OCC_W'(1);
            end
            cnt_q       <= cnt_d;
            stall_q     <= (cnt_d == CNT_W'(STARVE_LIMIT));
            rf_we_q     <= grant_a || grant_b;
            rf_from_b_q <= grant_b;
            if (grant_a) begin
                rf_rd_q   <= wb_rd_i;
                rf_data_q <= wb_data_i;
            end else if (grant_b) begin
                rf_rd_q   <= fifo_rd_q[head_idx];
                rf_data_q <= fifo_data_q[head_idx];
            end
        end
    end

    assign rf_we_o   = rf_we_q;
    assign rf_rd_o   = rf_rd_q;
    assign rf_data_o = rf_data_q;
    assign stall_o   = stall_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed scenarios with literal expectations
// plus a queue-based reference model compared against the DUT every cycle.
module tb_wb_port_arbiter;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned LIMIT  = 4;
    localparam int unsigned NREG   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wb_valid = 1'b0;
    logic [ADDR_W-1:0] wb_rd = '0;
    logic [DATA_W-1:0] wb_data = '0;
    logic              mc_valid = 1'b0;
    logic              mc_ready;
    logic [ADDR_W-1:0] mc_rd = '0;
    logic [DATA_W-1:0] mc_data = '0;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_data;
    logic              stall;
    logic [NREG-1:0]   busy_mask;

    wb_port_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clock_i(clk), .rst_i(rst),
        .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .mc_valid_i(mc_valid), .mc_ready_o(mc_ready), .mc_rd_i(mc_rd), .mc_data_i(mc_data),
        .rf_we_o(rf_we), .rf_rd_o(rf_rd), .rf_data_o(rf_data),
        .stall_o(stall), .busy_mask_o(busy_mask)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending B results and the expected write port
    logic [ADDR_W-1:0] q_rd   [$];
    logic [DATA_W-1:0] q_data [$];
    int                m_wait;
    logic              e_we, e_fromb, e_stall;
    logic [ADDR_W-1:0] e_rd;
    logic [DATA_W-1:0] e_data;

    function automatic logic [NREG-1:0] model_busy();
        logic [NREG-1:0] m = '0;
        foreach (q_rd[i]) m[q_rd[i]] = 1'b1;
        if (e_we && e_fromb) m[e_rd] = 1'b1;
        return m;
    endfunction

    initial begin
        e_we = 1'b0; e_fromb = 1'b0; e_stall = 1'b0; e_rd = '0; e_data = '0; m_wait = 0;
    end

    // Per-cycle compare against the model, then advance the model one clock
    initial forever begin
        int  src;
        bit  was_empty;
        bit  acc;
        @(negedge clk);
        if (rst) begin
            q_rd.delete(); q_data.delete();
            m_wait = 0; e_we = 1'b0; e_fromb = 1'b0; e_stall = 1'b0; e_rd = '0; e_data = '0;
            check("m_rst_we",    64'(rf_we),    64'(0));
            check("m_rst_ready", 64'(mc_ready), 64'(0));
            check("m_rst_busy",  64'(busy_mask), 64'(0));
            check("m_rst_stall", 64'(stall),    64'(0));
        end else begin
            check("m_we",    64'(rf_we),     64'(e_we));
            check("m_rd",    64'(rf_rd),     64'(e_rd));
            check("m_data",  64'(rf_data),   64'(e_data));
            check("m_stall", 64'(stall),     64'(e_stall));
            check("m_ready", 64'(mc_ready),  64'(q_rd.size() < DEPTH));
            check("m_busy",  64'(busy_mask), 64'(model_busy()));
            was_empty = (q_rd.size() == 0);
            acc       = mc_valid && (q_rd.size() < DEPTH);
            if (e_stall && !was_empty)  src = 2;
            else if (wb_valid)          src = 1;
            else if (!was_empty)        src = 2;
            else                        src = 0;
            e_we    = (src != 0);
            e_fromb = (src == 2);
            if (src == 1) begin
                e_rd = wb_rd; e_data = wb_data;
            end else if (src == 2) begin
                e_rd = q_rd.pop_front(); e_data = q_data.pop_front();
            end
            if (was_empty || src == 2) m_wait = 0;
            else if (m_wait < int'(LIMIT)) m_wait++;
            e_stall = (m_wait == int'(LIMIT));
            if (acc) begin
                q_rd.push_back(mc_rd); q_data.push_back(mc_data);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] got [$];
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        check("rst_ready", 64'(mc_ready), 64'(1));
        check("rst_we",    64'(rf_we),    64'(0));
        check("rst_rd",    64'(rf_rd),    64'(0));
        check("rst_busy",  64'(busy_mask), 64'(0));

        // A only
        wb_valid = 1'b1; wb_rd = 4'd3; wb_data = 16'h1234;
        cyc();
        wb_valid = 1'b0;
        check("a_we",    64'(rf_we),   64'(1));
        check("a_rd",    64'(rf_rd),   64'(3));
        check("a_data",  64'(rf_data), 64'h1234);
        check("a_stall", 64'(stall),   64'(0));

        // B only
        mc_valid = 1'b1; mc_rd = 4'd5; mc_data = 16'hBEEF;
        cyc();
        mc_valid = 1'b0;
        check("b_busy_t1", 64'(busy_mask[5]), 64'(1));
        check("b_we_t1",   64'(rf_we),        64'(0));
        cyc();
        check("b_we_t2",   64'(rf_we),        64'(1));
        check("b_rd_t2",   64'(rf_rd),        64'(5));
        check("b_data_t2", 64'(rf_data),      64'hBEEF);
        check("b_busy_t2", 64'(busy_mask[5]), 64'(1));
        cyc();
        check("b_busy_t3", 64'(busy_mask[5]), 64'(0));

        // Simultaneous A and queued B head: A first, then B
        mc_valid = 1'b1; mc_rd = 4'd7; mc_data = 16'h0707;
        cyc();
        mc_valid = 1'b0;
        wb_valid = 1'b1; wb_rd = 4'd2; wb_data = 16'h2222;
        cyc();
        wb_valid = 1'b0;
        check("sim_a_rd",   64'(rf_rd),        64'(2));
        check("sim_a_data", 64'(rf_data),      64'h2222);
        check("sim_busy7",  64'(busy_mask[7]), 64'(1));
        cyc();
        check("sim_b_we",   64'(rf_we),   64'(1));
        check("sim_b_rd",   64'(rf_rd),   64'(7));
        check("sim_b_data", 64'(rf_data), 64'h0707);
        cyc();

        // Starvation: head rd=9 under continuous A traffic
        wb_valid = 1'b1; wb_rd = 4'd1; wb_data = 16'h1111;
        mc_valid = 1'b1; mc_rd = 4'd9; mc_data = 16'h0909;
        cyc();
        mc_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("starve_wait", 64'(stall), 64'(0));
            cyc();
        end
        check("starve_stall", 64'(stall), 64'(1));
        check("starve_a_rd",  64'(rf_rd), 64'(1));
        cyc();
        check("starve_drop",  64'(stall),   64'(0));
        check("starve_b_rd",  64'(rf_rd),   64'(9));
        check("starve_b_dat", 64'(rf_data), 64'h0909);
        cyc();
        check("starve_resume_we", 64'(rf_we), 64'(1));
        check("starve_resume_rd", 64'(rf_rd), 64'(1));
        wb_valid = 1'b0;
        cyc();
        cyc();

        // Full FIFO holds the third result until a B grant frees a slot
        wb_valid = 1'b1; wb_rd = 4'd1; wb_data = 16'h1111;
        mc_valid = 1'b1; mc_rd = 4'd10; mc_data = 16'h00A0;
        cyc();
        mc_rd = 4'd11; mc_data = 16'h00B1;
        cyc();
        mc_rd = 4'd12; mc_data = 16'h00C2;
        for (int k = 0; k < 4; k++) begin
            check("full_ready0", 64'(mc_ready), 64'(0));
            cyc();
        end
        check("full_ready1", 64'(mc_ready), 64'(1));
        check("full_first",  64'(rf_rd),    64'(10));
        wb_valid = 1'b0;
        cyc();
        mc_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (rf_we) got.push_back(rf_rd);
            cyc();
        end
        check("full_count", 64'(got.size()), 64'(2));
        if (got.size() == 2) begin
            check("full_second", 64'(got[0]), 64'(11));
            check("full_third",  64'(got[1]), 64'(12));
        end

        // Reset mid-operation with two B entries queued
        wb_valid = 1'b1; wb_rd = 4'd1; wb_data = 16'h1111;
        mc_valid = 1'b1; mc_rd = 4'd13; mc_data = 16'h0D0D;
        cyc();
        mc_rd = 4'd14; mc_data = 16'h0E0E;
        cyc();
        mc_valid = 1'b0;
        check("pre_rst_busy", 64'(busy_mask), 64'(16'h6000));
        rst = 1'b1;
        #1;
        check("mid_rst_we",    64'(rf_we),     64'(0));
        check("mid_rst_ready", 64'(mc_ready),  64'(0));
        check("mid_rst_busy",  64'(busy_mask), 64'(0));
        cyc();
        check("mid_rst_ready2", 64'(mc_ready), 64'(0));
        rst = 1'b0; wb_valid = 1'b0;
        cyc();
        check("post_rst_ready", 64'(mc_ready),  64'(1));
        check("post_rst_busy",  64'(busy_mask), 64'(0));
        for (int k = 0; k < 5; k++) begin
            check("post_rst_no_we", 64'(rf_we), 64'(0));
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two requesters.
- Requester A is the pipeline writeback stage, i.e. the output of the memory/writeback pipeline registers.
- Requester B is a multicycle execution unit (mul/div) that returns results with a valid/ready handshake.
- B results are buffered in a small FIFO. A has priority. A starvation counter raises a one-cycle pipeline stall so B can drain. A busy mask is exported so decode can interlock on registers still pending from B.

Parameters:
- DATA_W, 16, register data width
- ADDR_W, 4, register address width (16 registers)
- DEPTH, 2, B-side FIFO entries (power of two, >=2)
- STARVE_LIMIT, 4, cycles a non-empty FIFO head may go ungranted before stall is raised (>=1)

Ports:
- clock  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wb_valid  in  1  pipeline writeback request this cycle
- wb_rd  in  ADDR_W  pipeline destination register
- wb_data  in  DATA_W  pipeline write data
- mc_valid  in  1  multicycle result valid
- mc_ready  out  1  arbiter can accept multicycle result
- mc_rd  in  ADDR_W  multicycle destination register
- mc_data  in  DATA_W  multicycle result data
- rf_we  out  1  register-file write enable (registered)
- rf_rd  out  ADDR_W  register-file write address (registered)
- rf_data  out  DATA_W  register-file write data (registered)
- stall  out  1  holds the pipeline registers for one cycle
- busy_mask  out  2**ADDR_W  bit i set while a B result for register i is pending

Behaviour:
- Reset (async, rst=1):
  - FIFO emptied, pointers = 0, starvation counter = 0.
  - rf_we=0, rf_rd=0, rf_data=0, stall=0, busy_mask=0.
  - mc_ready=0 while rst is high and =1 from the first cycle after release.
  - Results accepted before reset are discarded. The multicycle unit shares rst.
- B acceptance:
  - mc_ready = !full.
  - An entry is enqueued on a clock edge with mc_valid && mc_ready.
  - No bypass: an entry is grantable at the earliest in the cycle after acceptance.
- Grant, evaluated each cycle from current state:
  - stall=1 and FIFO non-empty: grant B (head). wb_valid is ignored this cycle because the pipeline is holding and re-presents the same request next cycle.
  - Else wb_valid=1: grant A.
  - Else FIFO non-empty: grant B.
  - Else no grant.
- Output stage:
  - On each edge, rf_we <= (grant present).
  - rf_rd/rf_data <= granted source's rd/data.
  - rf_rd/rf_data hold their previous value when there is no grant.
  - Latency: A request at cycle t gives rf_we=1 in cycle t+1. B accepted at t, granted at t+1, gives rf_we=1 at t+2.
- Dequeue: the FIFO head is popped on the edge where B is granted.
  - Enqueue and dequeue on the same edge are legal when not full. Occupancy is unchanged.
- Starvation counter:
  - Cleared when the FIFO is empty or on B grant.
  - Otherwise increments each cycle the head is ungranted, saturating at STARVE_LIMIT.
- stall = (counter == STARVE_LIMIT). It is a registered Moore output, so it is high for exactly one cycle per starvation event and drops after the forced B grant.
- busy_mask: bit i = OR over valid FIFO entries with rd==i, OR (rf_we && output stage sourced from B && rf_rd==i).
  - Decode must stall on busy bits. A WAW between A and a pending B entry is a decode-side violation and is not arbitrated here.
- Pointers wrap modulo DEPTH. Full/empty are distinguished by an extra pointer bit.
- mc_valid with mc_ready=0: the request is held by the source, nothing is dropped. mc_rd/mc_data must stay stable while waiting.

Test Plan:
- Reset mid-operation: 2 B entries queued, pulse rst -> rf_we=0, mc_ready=0 during reset, busy_mask=0, FIFO empty after release. No stale B write appears afterwards.
- A only: wb_valid=1, wb_rd=3, wb_data=16'h1234 at cycle t -> rf_we=1, rf_rd=3, rf_data=16'h1234 in cycle t+1. stall stays 0.
- B only: mc_valid=1, mc_rd=5, mc_data=16'hBEEF accepted at t -> busy_mask[5]=1 at t+1, rf_we=1 with rf_rd=5 / rf_data=16'hBEEF at t+2, busy_mask[5]=0 at t+3.
- Simultaneous: wb_valid and a queued B head (rd=7) in the same cycle -> A is written first, B is written the next cycle when wb_valid=0. Order is verified.
- Starvation: FIFO holds rd=9 and wb_valid=1 continuously -> stall=1 exactly one cycle after 4 ungranted cycles. rd=9 is written the following cycle, then the held A write resumes.
- Full: 2 entries accepted while wb_valid=1 -> mc_ready=0 and the third result is held. After one B grant, mc_ready=1 and the third result is accepted. All three are written in acceptance order.
